// File: rtl/div_issue_ctrl.sv
// Issue-side controller for the iterative divider: holds one DIV/REM instruction,
// starts the divider, waits for the result and hands it to the register file.
module div_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  logic [31:0] issue_opcode_i,
  input  logic [31:0] issue_pc_i,
  input  logic [4:0]  issue_rd_idx_i,
  input  logic [4:0]  issue_ra_idx_i,
  input  logic [4:0]  issue_rb_idx_i,
  input  logic [31:0] issue_ra_operand_i,
  input  logic [31:0] issue_rb_operand_i,
  input  logic        flush_i,
  output logic        div_valid_o,
  output logic [31:0] div_opcode_o,
  output logic [31:0] div_pc_o,
  output logic [4:0]  div_rd_idx_o,
  output logic [4:0]  div_ra_idx_o,
  output logic [4:0]  div_rb_idx_o,
  output logic [31:0] div_ra_operand_o,
  output logic [31:0] div_rb_operand_o,
  input  logic        div_wb_valid_i,
  input  logic [31:0] div_wb_value_i,
  output logic        rf_wb_valid_o,
  output logic [4:0]  rf_wb_rd_o,
  output logic [31:0] rf_wb_value_o,
  input  logic        rf_wb_ready_i,
  input  logic [4:0]  hazard_ra_idx_i,
  input  logic [4:0]  hazard_rb_idx_i,
  input  logic [4:0]  hazard_rd_idx_i,
  output logic        hazard_stall_o,
  output logic        busy_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_WB} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic             kill_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             wb_discard;
  logic             cnt_done;

  assign accept     = (state_q == S_IDLE) && !kill_q && issue_valid_i && !flush_i;
  // A flush landing in the same cycle as the result kills it just like kill_q.
  assign wb_discard = kill_q || flush_i || (div_rd_idx_o == 5'd0);
  assign cnt_done   = (cnt_q == CNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_SEND;
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (div_wb_valid_i) state_d = wb_discard ? S_IDLE : S_WB;
        else if (cnt_done)  state_d = S_IDLE;
      end
      S_WB:   if (flush_i || rf_wb_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    issue_ready_o = (state_q == S_IDLE) && !kill_q;
    div_valid_o   = (state_q == S_SEND);
    rf_wb_valid_o = (state_q == S_WB);
    busy_o        = (state_q != S_IDLE);
  end

  assign hazard_stall_o = busy_o && !kill_q && (div_rd_idx_o != 5'd0) &&
                          ((div_rd_idx_o == hazard_ra_idx_i) ||
                           (div_rd_idx_o == hazard_rb_idx_i) ||
                           (div_rd_idx_o == hazard_rd_idx_i));

  // NOTE: these are plain flops, not a memory, so every one gets a reset value
  // and the outputs are defined from the first cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kill_q           <= 1'b0;
      cnt_q            <= '0;
      timeout_o        <= 1'b0;
      div_opcode_o     <= '0;
      div_pc_o         <= '0;
      div_rd_idx_o     <= '0;
      div_ra_idx_o     <= '0;
      div_rb_idx_o     <= '0;
      div_ra_operand_o <= '0;
      div_rb_operand_o <= '0;
      rf_wb_rd_o       <= '0;
      rf_wb_value_o    <= '0;
    end else begin
      timeout_o <= (state_q == S_WAIT) && !div_wb_valid_i && cnt_done;

      if (accept) begin
        div_opcode_o     <= issue_opcode_i;
        div_pc_o         <= issue_pc_i;
        div_rd_idx_o     <= issue_rd_idx_i;
        div_ra_idx_o     <= issue_ra_idx_i;
        div_rb_idx_o     <= issue_rb_idx_i;
        div_ra_operand_o <= issue_ra_operand_i;
        div_rb_operand_o <= issue_rb_operand_i;
      end

      // The divider cannot be cancelled, so a kill lives until WAIT is left.
      if (accept) kill_q <= 1'b0;
      else if (flush_i && (state_q == S_SEND || state_q == S_WAIT)) kill_q <= 1'b1;
      if (state_q == S_WAIT && (div_wb_valid_i || cnt_done)) kill_q <= 1'b0;

      if (state_q == S_SEND) cnt_q <= '0;
      else if (state_q == S_WAIT && !cnt_done) cnt_q <= cnt_q + CNT_W'(1);

      if (state_q == S_WAIT && div_wb_valid_i && !wb_discard) begin
        rf_wb_rd_o    <= div_rd_idx_o;
        rf_wb_value_o <= div_wb_value_i;
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: the bench plays the divider and the
// register file, with hand-computed expected values per scenario.
module tb_div_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] issue_opcode_i, issue_pc_i;
  logic [4:0]  issue_rd_idx_i, issue_ra_idx_i, issue_rb_idx_i;
  logic [31:0] issue_ra_operand_i, issue_rb_operand_i;
  logic        flush_i;
  logic        div_valid_o;
  logic [31:0] div_opcode_o, div_pc_o;
  logic [4:0]  div_rd_idx_o, div_ra_idx_o, div_rb_idx_o;
  logic [31:0] div_ra_operand_o, div_rb_operand_o;
  logic        div_wb_valid_i;
  logic [31:0] div_wb_value_i;
  logic        rf_wb_valid_o;
  logic [4:0]  rf_wb_rd_o;
  logic [31:0] rf_wb_value_o;
  logic        rf_wb_ready_i;
  logic [4:0]  hazard_ra_idx_i, hazard_rb_idx_i, hazard_rd_idx_i;
  logic        hazard_stall_o, busy_o, timeout_o;

  int checks = 0;
  int errors = 0;
  bit seen_ready, seen_dv, seen_rfv;

  div_issue_ctrl #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_opcode_i(issue_opcode_i), .issue_pc_i(issue_pc_i),
    .issue_rd_idx_i(issue_rd_idx_i), .issue_ra_idx_i(issue_ra_idx_i),
    .issue_rb_idx_i(issue_rb_idx_i),
    .issue_ra_operand_i(issue_ra_operand_i), .issue_rb_operand_i(issue_rb_operand_i),
    .flush_i(flush_i),
    .div_valid_o(div_valid_o), .div_opcode_o(div_opcode_o), .div_pc_o(div_pc_o),
    .div_rd_idx_o(div_rd_idx_o), .div_ra_idx_o(div_ra_idx_o), .div_rb_idx_o(div_rb_idx_o),
    .div_ra_operand_o(div_ra_operand_o), .div_rb_operand_o(div_rb_operand_o),
    .div_wb_valid_i(div_wb_valid_i), .div_wb_value_i(div_wb_value_i),
    .rf_wb_valid_o(rf_wb_valid_o), .rf_wb_rd_o(rf_wb_rd_o), .rf_wb_value_o(rf_wb_value_o),
    .rf_wb_ready_i(rf_wb_ready_i),
    .hazard_ra_idx_i(hazard_ra_idx_i), .hazard_rb_idx_i(hazard_rb_idx_i),
    .hazard_rd_idx_i(hazard_rd_idx_i), .hazard_stall_o(hazard_stall_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and observe just after the edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
    if (issue_ready_o) seen_ready = 1'b1;
    if (div_valid_o)   seen_dv    = 1'b1;
    if (rf_wb_valid_o) seen_rfv   = 1'b1;
  endtask

  task automatic clr_seen();
    seen_ready = 1'b0;
    seen_dv    = 1'b0;
    seen_rfv   = 1'b0;
  endtask

  // Offer one instruction; returns positioned in the first WAIT cycle.
  task automatic issue_instr(input logic [31:0] op, input logic [31:0] pc,
                             input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                             input logic [31:0] a, input logic [31:0] b);
    issue_opcode_i = op; issue_pc_i = pc;
    issue_rd_idx_i = rd; issue_ra_idx_i = ra; issue_rb_idx_i = rb;
    issue_ra_operand_i = a; issue_rb_operand_i = b;
    issue_valid_i = 1'b1;
    checks++;
    if (issue_ready_o !== 1'b1) begin
      errors++; $display("FAIL issue_ready_before_accept got %b exp 1", issue_ready_o);
    end
    cyc();
    issue_valid_i = 1'b0;
    checks++;
    if (div_valid_o !== 1'b1) begin
      errors++; $display("FAIL div_valid_pulse got %b exp 1", div_valid_o);
    end
    checks++;
    if ({div_opcode_o, div_pc_o, div_rd_idx_o, div_ra_idx_o, div_rb_idx_o,
         div_ra_operand_o, div_rb_operand_o} !== {op, pc, rd, ra, rb, a, b}) begin
      errors++;
      $display("FAIL div_fields got %h %h %h %h %h %h %h exp %h %h %h %h %h %h %h",
               div_opcode_o, div_pc_o, div_rd_idx_o, div_ra_idx_o, div_rb_idx_o,
               div_ra_operand_o, div_rb_operand_o, op, pc, rd, ra, rb, a, b);
    end
    cyc();
    checks++;
    if (div_valid_o !== 1'b0) begin
      errors++; $display("FAIL div_valid_one_cycle got %b exp 0", div_valid_o);
    end
  endtask

  // Divider model: result pulse lat cycles after the start pulse; returns in cycle M+1.
  task automatic wait_result(input int lat, input logic [31:0] val);
    clr_seen();
    repeat (lat - 1) cyc();
    checks++;
    if ({seen_ready, seen_dv} !== 2'b00) begin
      errors++; $display("FAIL wait_quiet got ready=%b div_valid=%b exp 0 0", seen_ready, seen_dv);
    end
    div_wb_valid_i = 1'b1;
    div_wb_value_i = val;
    cyc();
    div_wb_valid_i = 1'b0;
    div_wb_value_i = '0;
  endtask

  task automatic test_reset();
    checks++;
    if ({issue_ready_o, div_valid_o, busy_o, timeout_o, hazard_stall_o, rf_wb_valid_o} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 100000",
               {issue_ready_o, div_valid_o, busy_o, timeout_o, hazard_stall_o, rf_wb_valid_o});
    end
    checks++;
    if ({div_opcode_o, div_pc_o, div_rd_idx_o, div_ra_idx_o, div_rb_idx_o,
         div_ra_operand_o, div_rb_operand_o, rf_wb_rd_o, rf_wb_value_o} !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h exp 0", div_opcode_o, rf_wb_rd_o, rf_wb_value_o);
    end
  endtask

  task automatic test_basic_divu();
    rf_wb_ready_i = 1'b1;
    issue_instr(32'h0271_52b3, 32'h0000_1000, 5'd5, 5'd1, 5'd2, 32'd100, 32'd7);
    wait_result(34, 32'd14);
    checks++;
    if ({rf_wb_valid_o, rf_wb_rd_o, rf_wb_value_o} !== {1'b1, 5'd5, 32'd14}) begin
      errors++; $display("FAIL divu_wb got %b %0d %0d exp 1 5 14", rf_wb_valid_o, rf_wb_rd_o, rf_wb_value_o);
    end
    cyc();
    checks++;
    if ({rf_wb_valid_o, issue_ready_o, busy_o} !== 3'b010) begin
      errors++; $display("FAIL divu_done got %b exp 010", {rf_wb_valid_o, issue_ready_o, busy_o});
    end
  endtask

  task automatic test_backpressure();
    issue_instr(32'h0230_e1b3, 32'h0000_1004, 5'd3, 5'd6, 5'd4, 32'hFFFF_FFFF, 32'd5);
    rf_wb_ready_i = 1'b0;
    wait_result(34, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rf_wb_valid_o, rf_wb_rd_o, rf_wb_value_o} !== {1'b1, 5'd3, 32'hFFFF_FFFF}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got %b %0d %h exp 1 3 ffffffff", i, rf_wb_valid_o, rf_wb_rd_o, rf_wb_value_o);
      end
      if (i < 4) cyc();
    end
    rf_wb_ready_i = 1'b1;
    cyc();
    checks++;
    if ({busy_o, rf_wb_valid_o, issue_ready_o} !== 3'b001) begin
      errors++; $display("FAIL bp_release got %b exp 001", {busy_o, rf_wb_valid_o, issue_ready_o});
    end
  endtask

  task automatic test_hazard();
    hazard_rb_idx_i = 5'd9;
    issue_instr(32'h0220_c4b3, 32'h0000_1008, 5'd9, 5'd1, 5'd2, 32'd81, 32'd9);
    checks++;
    if (hazard_stall_o !== 1'b1) begin
      errors++; $display("FAIL hazard_rb_match got %b exp 1", hazard_stall_o);
    end
    hazard_rb_idx_i = 5'd10;
    #1;
    checks++;
    if (hazard_stall_o !== 1'b0) begin
      errors++; $display("FAIL hazard_no_match got %b exp 0", hazard_stall_o);
    end
    hazard_rb_idx_i = 5'd9;
    wait_result(20, 32'd9);
    checks++;
    if ({rf_wb_valid_o, hazard_stall_o} !== 2'b11) begin
      errors++; $display("FAIL hazard_in_wb got %b exp 11", {rf_wb_valid_o, hazard_stall_o});
    end
    cyc();
    checks++;
    if (hazard_stall_o !== 1'b0) begin
      errors++; $display("FAIL hazard_after_wb got %b exp 0", hazard_stall_o);
    end
    hazard_rb_idx_i = 5'd0;
    hazard_ra_idx_i = 5'd0;
    issue_instr(32'h0220_c033, 32'h0000_100c, 5'd0, 5'd1, 5'd2, 32'd8, 32'd2);
    checks++;
    if (hazard_stall_o !== 1'b0) begin
      errors++; $display("FAIL hazard_rd0 got %b exp 0", hazard_stall_o);
    end
    wait_result(10, 32'd4);
    checks++;
    if ({rf_wb_valid_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL rd0_no_write got %b exp 00", {rf_wb_valid_o, busy_o});
    end
  endtask

  task automatic test_flush();
    hazard_rd_idx_i = 5'd7;
    issue_instr(32'h0220_d3b3, 32'h0000_1010, 5'd7, 5'd1, 5'd2, 32'd70, 32'd10);
    repeat (10) cyc();
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    checks++;
    if ({busy_o, hazard_stall_o, issue_ready_o} !== 3'b100) begin
      errors++; $display("FAIL flush_killed got %b exp 100", {busy_o, hazard_stall_o, issue_ready_o});
    end
    clr_seen();
    repeat (22) cyc();
    checks++;
    if (seen_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready_held got %b exp 0", seen_ready);
    end
    div_wb_valid_i = 1'b1;
    div_wb_value_i = 32'd7;
    cyc();
    div_wb_valid_i = 1'b0;
    checks++;
    if ({seen_rfv, rf_wb_valid_o, busy_o, issue_ready_o} !== 4'b0001) begin
      errors++;
      $display("FAIL flush_discard got %b exp 0001", {seen_rfv, rf_wb_valid_o, busy_o, issue_ready_o});
    end
    hazard_rd_idx_i = 5'd0;
    issue_valid_i = 1'b1;
    flush_i = 1'b1;
    cyc();
    issue_valid_i = 1'b0;
    flush_i = 1'b0;
    checks++;
    if ({busy_o, div_valid_o, issue_ready_o} !== 3'b001) begin
      errors++; $display("FAIL flush_beats_issue got %b exp 001", {busy_o, div_valid_o, issue_ready_o});
    end
  endtask

  task automatic test_timeout();
    issue_instr(32'h0220_c2b3, 32'h0000_1014, 5'd11, 5'd1, 5'd2, 32'd1, 32'd1);
    clr_seen();
    repeat (40) cyc();
    checks++;
    if ({seen_ready, busy_o, timeout_o} !== 3'b010) begin
      errors++; $display("FAIL timeout_pending got %b exp 010", {seen_ready, busy_o, timeout_o});
    end
    cyc();
    checks++;
    if ({timeout_o, busy_o, issue_ready_o} !== 3'b101) begin
      errors++; $display("FAIL timeout_fire got %b exp 101", {timeout_o, busy_o, issue_ready_o});
    end
    div_wb_valid_i = 1'b1;
    div_wb_value_i = 32'hDEAD_BEEF;
    cyc();
    div_wb_valid_i = 1'b0;
    checks++;
    if (timeout_o !== 1'b0) begin
      errors++; $display("FAIL timeout_one_pulse got %b exp 0", timeout_o);
    end
    cyc();
    checks++;
    if ({rf_wb_valid_o, busy_o, rf_wb_value_o == 32'hDEAD_BEEF} !== 3'b000) begin
      errors++; $display("FAIL late_result got valid=%b busy=%b value=%h", rf_wb_valid_o, busy_o, rf_wb_value_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 2; n++) begin
      issue_instr(32'h0276_4633, 32'h0000_1018, 5'd12, 5'd13, 5'd14, 32'hFFFF_FFCE, 32'd7);
      wait_result((n == 0) ? 34 : 2, 32'hFFFF_FFF9);
      checks++;
      if ({rf_wb_valid_o, rf_wb_rd_o, rf_wb_value_o} !== {1'b1, 5'd12, 32'hFFFF_FFF9}) begin
        errors++;
        $display("FAIL repeat_wb[%0d] got %b %0d %h exp 1 12 fffffff9", n, rf_wb_valid_o, rf_wb_rd_o, rf_wb_value_o);
      end
      cyc();
    end
    issue_instr(32'h0276_5633, 32'h0000_101c, 5'd13, 5'd1, 5'd2, 32'h0002_4680, 32'd2);
    wait_result(1, 32'h0001_2340);
    checks++;
    if ({rf_wb_valid_o, rf_wb_rd_o, rf_wb_value_o} !== {1'b1, 5'd13, 32'h0001_2340}) begin
      errors++; $display("FAIL lat1_wb got %b %0d %h exp 1 13 00012340", rf_wb_valid_o, rf_wb_rd_o, rf_wb_value_o);
    end
    cyc();
  endtask

  task automatic test_reset_mid_op();
    hazard_ra_idx_i = 5'd15;
    issue_instr(32'h0221_47b3, 32'h0000_1020, 5'd15, 5'd3, 5'd4, 32'd99, 32'd3);
    repeat (3) cyc();
    checks++;
    if (hazard_stall_o !== 1'b1) begin
      errors++; $display("FAIL pre_reset_stall got %b exp 1", hazard_stall_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    test_reset();
    div_wb_valid_i = 1'b1;
    div_wb_value_i = 32'd33;
    cyc();
    div_wb_valid_i = 1'b0;
    rst_i = 1'b0;
    cyc();
    checks++;
    if ({rf_wb_valid_o, busy_o, issue_ready_o} !== 3'b001) begin
      errors++; $display("FAIL post_reset_idle got %b exp 001", {rf_wb_valid_o, busy_o, issue_ready_o});
    end
    hazard_ra_idx_i = 5'd0;
  endtask

  initial begin
    rst_i = 1'b1;
    issue_valid_i = 1'b0; flush_i = 1'b0;
    issue_opcode_i = '0; issue_pc_i = '0;
    issue_rd_idx_i = '0; issue_ra_idx_i = '0; issue_rb_idx_i = '0;
    issue_ra_operand_i = '0; issue_rb_operand_i = '0;
    div_wb_valid_i = 1'b0; div_wb_value_i = '0;
    rf_wb_ready_i = 1'b1;
    hazard_ra_idx_i = '0; hazard_rb_idx_i = '0; hazard_rd_idx_i = '0;
    clr_seen();
    #12;
    test_reset();
    cyc();
    rst_i = 1'b0;
    cyc();
    test_basic_divu();
    test_backpressure();
    test_hazard();
    test_flush();
    test_timeout();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout got running exp finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
